// File: rtl/intrp_cntrl_pri_if.sv
// Configuration bus for intrp_cntrl_pri: APB-style select/enable/write access
// with zero-wait-state ready and error response.
interface intrp_cntrl_pri_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  sel;
    logic                  enable;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH-1:0]      rdata;
    logic                  ready;
    logic                  error;

    modport master (
        output sel, enable, write, addr, wdata,
        input  rdata, ready, error
    );

    modport slave (
        input  sel, enable, write, addr, wdata,
        output rdata, ready, error
    );
endinterface

// File: rtl/intrp_cntrl_pri.sv
// Priority interrupt controller: edge-latched pending bits, mask/enable, priority
// arbitration and a grant-until-serviced handshake. INTRP_FCFS_EN adds age-based arbitration.
module intrp_cntrl_pri #(
    parameter int NUM_PHER   = 16,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int PRI_WIDTH  = $clog2(NUM_PHER),
    parameter int ID_WIDTH   = $clog2(NUM_PHER)
) (
    input  logic                clk,
    input  logic                rst_n,
    intrp_cntrl_pri_if.slave    bus,
    input  logic [NUM_PHER-1:0] int_valid,
    output logic                intrp_valid,
    output logic [ID_WIDTH-1:0] pher_with_intrp,
    input  logic                intrp_serviced
);

    localparam logic [ADDR_WIDTH-1:0] A_MASK = ADDR_WIDTH'(NUM_PHER);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(NUM_PHER + 1);
    localparam logic [ADDR_WIDTH-1:0] A_PEND = ADDR_WIDTH'(NUM_PHER + 2);
`ifdef INTRP_FCFS_EN
    localparam logic [ADDR_WIDTH-1:0] A_MODE = ADDR_WIDTH'(NUM_PHER + 3);
    localparam int AGE_W = ID_WIDTH + 2;
    localparam int KEY_W = AGE_W + PRI_WIDTH;
`else
    localparam int KEY_W = PRI_WIDTH;
`endif

    typedef enum logic {IDLE, GRANT} state_t;

    logic [PRI_WIDTH-1:0] pri_q [NUM_PHER];
    logic [NUM_PHER-1:0]  mask_q;
    logic                 en_q;
    logic [NUM_PHER-1:0]  int_q;
    logic [NUM_PHER-1:0]  pending_q;
    logic [NUM_PHER-1:0]  rise;
    logic [NUM_PHER-1:0]  cand;
    logic [NUM_PHER-1:0]  clr;
    state_t               state_q, state_d;
    logic [ID_WIDTH-1:0]  winner_q;
    logic [ID_WIDTH-1:0]  best_idx;
    logic [KEY_W-1:0]     best_key;
    logic [KEY_W-1:0]     key [NUM_PHER];
    logic                 best_found;
    logic                 grant_load;
    logic                 access, wr_en;
    logic                 is_pri, is_mask, is_ctrl, is_pend, is_mode, mapped;
    logic [ID_WIDTH-1:0]  pri_idx;
    logic [WIDTH-1:0]     rd_val;
`ifdef INTRP_FCFS_EN
    logic                 mode_q;
    logic [AGE_W-1:0]     age_q [NUM_PHER];
`endif

    // Address decode and bus response
    always_comb begin
        access  = bus.sel & bus.enable;
        is_pri  = bus.addr < A_MASK;
        is_mask = bus.addr == A_MASK;
        is_ctrl = bus.addr == A_CTRL;
        is_pend = bus.addr == A_PEND;
`ifdef INTRP_FCFS_EN
        is_mode = bus.addr == A_MODE;
`else
        is_mode = 1'b0;
`endif
        mapped  = is_pri | is_mask | is_ctrl | is_pend | is_mode;
        pri_idx = bus.addr[ID_WIDTH-1:0];
        wr_en   = access & bus.write & mapped & ~is_pend;
    end

    always_comb begin
        rd_val = '0;
        if (is_pri)       rd_val = WIDTH'(pri_q[pri_idx]);
        else if (is_mask) rd_val = WIDTH'(mask_q);
        else if (is_ctrl) rd_val = WIDTH'(en_q);
        else if (is_pend) rd_val = WIDTH'(pending_q);
`ifdef INTRP_FCFS_EN
        else if (is_mode) rd_val = WIDTH'(mode_q);
`endif
    end

    assign bus.ready = access;
    assign bus.error = access & (~mapped | (bus.write & is_pend));
    assign bus.rdata = (access & ~bus.error) ? rd_val : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PHER; i++) pri_q[i] <= '0;
            mask_q <= '1;
            en_q   <= 1'b1;
        end else if (wr_en) begin
            if (is_pri)  pri_q[pri_idx] <= bus.wdata[PRI_WIDTH-1:0];
            if (is_mask) mask_q <= bus.wdata[NUM_PHER-1:0];
            if (is_ctrl) en_q <= bus.wdata[0];
        end
    end

    // int_q resets high so requests already asserted at reset release need a fresh edge
    assign rise = int_valid & ~int_q;
    assign cand = pending_q & mask_q & {NUM_PHER{en_q}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q     <= '1;
            pending_q <= '0;
        end else begin
            int_q     <= int_valid;
            pending_q <= (pending_q & ~clr) | rise;
        end
    end

`ifdef INTRP_FCFS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (wr_en && is_mode) begin
            mode_q <= bus.wdata[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PHER; i++) age_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PHER; i++) begin
                if (rise[i] && (!pending_q[i] || clr[i])) begin
                    age_q[i] <= '0;
                end else if (pending_q[i] && !clr[i]) begin
                    if (age_q[i] != '1) age_q[i] <= age_q[i] + 1'b1;
                end else if (clr[i]) begin
                    age_q[i] <= '0;
                end
            end
        end
    end

    // Age dominates the comparison key in FCFS mode; priority breaks age ties
    always_comb begin
        for (int unsigned i = 0; i < NUM_PHER; i++)
            key[i] = mode_q ? {age_q[i], pri_q[i]} : {{AGE_W{1'b0}}, pri_q[i]};
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < NUM_PHER; i++) key[i] = pri_q[i];
    end
`endif

    // Strictly-greater replacement keeps the lower index on equal keys
    always_comb begin
        best_found = 1'b0;
        best_idx   = '0;
        best_key   = '0;
        for (int unsigned i = 0; i < NUM_PHER; i++) begin
            if (cand[i] && (!best_found || key[i] > best_key)) begin
                best_found = 1'b1;
                best_idx   = ID_WIDTH'(i);
                best_key   = key[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        clr        = '0;
        case (state_q)
            IDLE: begin
                if (best_found) begin
                    state_d    = GRANT;
                    grant_load = 1'b1;
                end
            end
            GRANT: begin
                if (intrp_serviced) begin
                    state_d = IDLE;
                    clr     = NUM_PHER'(1) << winner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            winner_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_load) winner_q <= best_idx;
        end
    end

    assign intrp_valid     = (state_q == GRANT);
    assign pher_with_intrp = winner_q;

endmodule

// File: tb/tb_intrp_cntrl_pri.sv
// Self-checking bench for intrp_cntrl_pri: directed scenarios plus randomized
// priority/mask bursts checked against a behavioural grant-order model.
module tb_intrp_cntrl_pri;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] int_valid = '0;
    logic        intrp_serviced = 1'b0;
    logic        intrp_valid;
    logic [3:0]  pher_with_intrp;

    intrp_cntrl_pri_if #(.WIDTH(16), .ADDR_WIDTH(16)) bus ();

    intrp_cntrl_pri #(.NUM_PHER(16), .WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .int_valid       (int_valid),
        .intrp_valid     (intrp_valid),
        .pher_with_intrp (pher_with_intrp),
        .intrp_serviced  (intrp_serviced)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference register state
    int          m_pri [16];
    logic [15:0] m_mask;
    logic        m_en;

    // Highest priority value first, lowest index within a priority level
    function automatic int model_pick(input logic [15:0] c);
        for (int p = 15; p >= 0; p--)
            for (int i = 0; i < 16; i++)
                if (c[i] && m_pri[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pri[i] = 0;
        m_mask = 16'hFFFF;
        m_en   = 1'b1;
    endtask

    task automatic apply_reset();
        int_valid = '0;
        intrp_serviced = 1'b0;
        bus.sel = 1'b0; bus.enable = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic bus_access(input logic wr, input int a, input logic [15:0] d,
                              output logic [15:0] rd, output logic rdy, output logic err);
        @(negedge clk);
        bus.sel = 1'b1; bus.enable = 1'b0; bus.write = wr; bus.addr = a[15:0]; bus.wdata = d;
        @(negedge clk);
        bus.enable = 1'b1;
        #1;
        rd = bus.rdata; rdy = bus.ready; err = bus.error;
        @(negedge clk);
        bus.sel = 1'b0; bus.enable = 1'b0; bus.write = 1'b0; bus.wdata = '0;
    endtask

    task automatic cfg_write(input int a, input logic [15:0] d);
        logic [15:0] rd; logic rdy, err;
        bus_access(1'b1, a, d, rd, rdy, err);
        if (a < 16)       m_pri[a] = int'(d[3:0]);
        else if (a == 16) m_mask = d;
        else if (a == 17) m_en = d[0];
    endtask

    task automatic bus_read(input int a, output logic [15:0] rd, output logic err);
        logic rdy;
        bus_access(1'b0, a, '0, rd, rdy, err);
    endtask

    // Waits (bounded) for a grant, acknowledges it, and reports intrp_valid one and two edges later
    task automatic grab(output logic ok, output logic [3:0] id,
                        output logic v_s, output logic v_s1);
        ok = 1'b0; id = '0; v_s = 1'b1; v_s1 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (intrp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) return;
        id = pher_with_intrp;
        intrp_serviced = 1'b1;
        @(negedge clk);
        intrp_serviced = 1'b0;
        v_s = intrp_valid;
        @(negedge clk);
        v_s1 = intrp_valid;
    endtask

    task automatic run_burst(input logic [15:0] lines, input string tag);
        logic [15:0] cand, rem, rd;
        logic ok, v_s, v_s1, err;
        logic [3:0] id;
        int exp;
        cand = lines & m_mask & {16{m_en}};
        @(negedge clk);
        int_valid = lines;
        @(negedge clk);
        checks++;
        if (intrp_valid !== 1'b0) begin
            failures++; $display("FAIL %s latency_k: got %b expected 0", tag, intrp_valid);
        end
        @(negedge clk);
        checks++;
        if (intrp_valid !== (cand != 0)) begin
            failures++; $display("FAIL %s latency_k1: got %b expected %b", tag, intrp_valid, cand != 0);
        end
        rem = cand;
        for (int g = 0; g < 16 && rem != 0; g++) begin
            exp = model_pick(rem);
            rem[exp] = 1'b0;
            grab(ok, id, v_s, v_s1);
            checks++;
            if (!ok || id !== 4'(exp)) begin
                failures++; $display("FAIL %s grant%0d: got %0d (valid %b) expected %0d", tag, g, id, ok, exp);
            end
            checks++;
            if (v_s !== 1'b0 || v_s1 !== (rem != 0)) begin
                failures++; $display("FAIL %s gap%0d: got %b%b expected 0%b", tag, g, v_s, v_s1, rem != 0);
            end
        end
        bus_read(18, rd, err);
        checks++;
        if (rd !== (lines & ~cand) || err !== 1'b0) begin
            failures++; $display("FAIL %s pend_after: got %h err %b expected %h", tag, rd, err, lines & ~cand);
        end
        int_valid = '0;
    endtask

    task automatic test_reset();
        logic [15:0] rd; logic err;
        int_valid = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (intrp_valid !== 1'b0 || pher_with_intrp !== 4'd0) begin
            failures++; $display("FAIL reset_in: got valid %b id %0d expected 0 0", intrp_valid, pher_with_intrp);
        end
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        checks++;
        if (bus.rdata !== 16'h0 || bus.ready !== 1'b0 || bus.error !== 1'b0 ||
            intrp_valid !== 1'b0 || pher_with_intrp !== 4'd0) begin
            failures++; $display("FAIL reset_out: got rdata %h ready %b error %b valid %b id %0d expected all 0",
                                 bus.rdata, bus.ready, bus.error, intrp_valid, pher_with_intrp);
        end
        bus_read(3, rd, err);
        checks++;
        if (rd !== 16'h0000) begin failures++; $display("FAIL reset_pri3: got %h expected 0000", rd); end
        bus_read(16, rd, err);
        checks++;
        if (rd !== 16'hFFFF) begin failures++; $display("FAIL reset_mask: got %h expected ffff", rd); end
        bus_read(17, rd, err);
        checks++;
        if (rd !== 16'h0001) begin failures++; $display("FAIL reset_ctrl: got %h expected 0001", rd); end
        bus_read(18, rd, err);
        checks++;
        if (rd !== 16'h0000) begin failures++; $display("FAIL reset_pend: got %h expected 0000", rd); end
    endtask

    task automatic test_ascending();
        apply_reset();
        for (int i = 0; i < 16; i++) cfg_write(i, 16'(i));
        run_burst(16'hFFFF, "ascending");
    endtask

    task automatic test_descending();
        apply_reset();
        for (int i = 0; i < 16; i++) cfg_write(i, 16'(15 - i));
        run_burst(16'hFFFF, "descending");
    endtask

    task automatic test_mask();
        logic [15:0] rd; logic err, ok, v_s, v_s1; logic [3:0] id;
        apply_reset();
        cfg_write(16, 16'hFFFE);
        @(negedge clk);
        int_valid[0] = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (intrp_valid !== 1'b0) begin failures++; $display("FAIL mask_blocks: got %b expected 0", intrp_valid); end
        bus_read(18, rd, err);
        checks++;
        if (rd !== 16'h0001) begin failures++; $display("FAIL mask_pend: got %h expected 0001", rd); end
        cfg_write(16, 16'hFFFF);
        checks++;
        if (intrp_valid !== 1'b0) begin failures++; $display("FAIL mask_commit_edge: got %b expected 0", intrp_valid); end
        @(negedge clk);
        checks++;
        if (intrp_valid !== 1'b1 || pher_with_intrp !== 4'd0) begin
            failures++; $display("FAIL mask_next_edge: got valid %b id %0d expected 1 0", intrp_valid, pher_with_intrp);
        end
        grab(ok, id, v_s, v_s1);
        checks++;
        if (!ok || id !== 4'd0 || v_s !== 1'b0 || v_s1 !== 1'b0) begin
            failures++; $display("FAIL mask_service: got ok %b id %0d %b%b expected 1 0 00", ok, id, v_s, v_s1);
        end
        int_valid = '0;
    endtask

    task automatic test_errors();
        logic [15:0] rd; logic rdy, err;
        apply_reset();
        cfg_write(1, 16'hFFFF);
        bus_read(1, rd, err);
        checks++;
        if (rd !== 16'h000F || err !== 1'b0) begin
            failures++; $display("FAIL pri_upper_bits: got %h err %b expected 000f 0", rd, err);
        end
        bus_access(1'b1, 18, 16'hFFFF, rd, rdy, err);
        checks++;
        if (rdy !== 1'b1 || err !== 1'b1) begin
            failures++; $display("FAIL pend_write: got ready %b error %b expected 1 1", rdy, err);
        end
        bus_read(18, rd, err);
        checks++;
        if (rd !== 16'h0000) begin failures++; $display("FAIL pend_unchanged: got %h expected 0000", rd); end
        bus_access(1'b1, 16'h0040, 16'h1234, rd, rdy, err);
        checks++;
        if (rdy !== 1'b1 || err !== 1'b1 || rd !== 16'h0000) begin
            failures++; $display("FAIL bad_addr_write: got ready %b error %b rdata %h expected 1 1 0000", rdy, err, rd);
        end
        bus_read(1, rd, err);
        checks++;
        if (rd !== 16'h000F) begin failures++; $display("FAIL bad_addr_pri1: got %h expected 000f", rd); end
        bus_read(16, rd, err);
        checks++;
        if (rd !== 16'hFFFF) begin failures++; $display("FAIL bad_addr_mask: got %h expected ffff", rd); end
`ifndef INTRP_FCFS_EN
        bus_access(1'b0, 19, '0, rd, rdy, err);
        checks++;
        if (rdy !== 1'b1 || err !== 1'b1 || rd !== 16'h0000) begin
            failures++; $display("FAIL mode_unmapped: got ready %b error %b rdata %h expected 1 1 0000", rdy, err, rd);
        end
`endif
    endtask

    task automatic test_set_wins();
        logic ok, v_s, v_s1; logic [3:0] id;
        apply_reset();
        @(negedge clk);
        int_valid[5] = 1'b1;
        @(negedge clk);
        int_valid[5] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (intrp_valid !== 1'b1 || pher_with_intrp !== 4'd5) begin
            failures++; $display("FAIL setwins_grant: got valid %b id %0d expected 1 5", intrp_valid, pher_with_intrp);
        end
        int_valid[5] = 1'b1;
        intrp_serviced = 1'b1;
        @(negedge clk);
        intrp_serviced = 1'b0;
        checks++;
        if (intrp_valid !== 1'b0) begin failures++; $display("FAIL setwins_drop: got %b expected 0", intrp_valid); end
        @(negedge clk);
        grab(ok, id, v_s, v_s1);
        checks++;
        if (!ok || id !== 4'd5 || v_s1 !== 1'b0) begin
            failures++; $display("FAIL setwins_regrant: got ok %b id %0d next %b expected 1 5 0", ok, id, v_s1);
        end
        int_valid = '0;
    endtask

    task automatic test_reset_mid_grant();
        logic [15:0] rd; logic err, ok, v_s, v_s1; logic [3:0] id;
        apply_reset();
        cfg_write(3, 16'd7);
        @(negedge clk);
        int_valid[3] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (intrp_valid !== 1'b1 || pher_with_intrp !== 4'd3) begin
            failures++; $display("FAIL midrst_grant: got valid %b id %0d expected 1 3", intrp_valid, pher_with_intrp);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (intrp_valid !== 1'b0 || pher_with_intrp !== 4'd0) begin
            failures++; $display("FAIL midrst_async: got valid %b id %0d expected 0 0", intrp_valid, pher_with_intrp);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        bus_read(18, rd, err);
        checks++;
        if (intrp_valid !== 1'b0 || rd !== 16'h0000) begin
            failures++; $display("FAIL midrst_level: got valid %b pend %h expected 0 0000", intrp_valid, rd);
        end
        int_valid[3] = 1'b0;
        @(negedge clk);
        int_valid[3] = 1'b1;
        @(negedge clk);
        grab(ok, id, v_s, v_s1);
        checks++;
        if (!ok || id !== 4'd3) begin
            failures++; $display("FAIL midrst_reedge: got ok %b id %0d expected 1 3", ok, id);
        end
        int_valid = '0;
    endtask

    task automatic test_random();
        logic [15:0] lines, d;
        for (int it = 0; it < 8; it++) begin
            apply_reset();
            for (int i = 0; i < 16; i++) begin
                d = 16'($urandom);
                cfg_write(i, d);
            end
            cfg_write(16, 16'($urandom));
            cfg_write(17, 16'($urandom_range(0, 3) != 0));
            lines = 16'($urandom_range(1, 16'hFFFF));
            run_burst(lines, "random");
        end
    endtask

`ifdef INTRP_FCFS_EN
    task automatic test_fcfs();
        logic [15:0] rd; logic err, ok, v_s, v_s1; logic [3:0] id;
        int first, second;
        for (int m = 1; m >= 0; m--) begin
            apply_reset();
            cfg_write(19, 16'(m));
            bus_read(19, rd, err);
            checks++;
            if (rd !== 16'(m) || err !== 1'b0) begin
                failures++; $display("FAIL fcfs_mode_rd: got %h err %b expected %0d 0", rd, err, m);
            end
            for (int i = 0; i < 16; i++) cfg_write(i, 16'(i));
            cfg_write(17, 16'h0);
            @(negedge clk);
            int_valid[2] = 1'b1;
            repeat (3) @(negedge clk);
            int_valid[9] = 1'b1;
            cfg_write(17, 16'h1);
            first  = (m == 1) ? 2 : 9;
            second = (m == 1) ? 9 : 2;
            grab(ok, id, v_s, v_s1);
            checks++;
            if (!ok || id !== 4'(first)) begin
                failures++; $display("FAIL fcfs_mode%0d_first: got %0d expected %0d", m, id, first);
            end
            grab(ok, id, v_s, v_s1);
            checks++;
            if (!ok || id !== 4'(second)) begin
                failures++; $display("FAIL fcfs_mode%0d_second: got %0d expected %0d", m, id, second);
            end
            int_valid = '0;
        end
    endtask
`endif

    initial begin
        bus.sel = 1'b0; bus.enable = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_ascending();
        test_descending();
        test_mask();
        test_errors();
        test_set_wins();
        test_reset_mid_grant();
        test_random();
`ifdef INTRP_FCFS_EN
        test_fcfs();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
